// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS constants and types.
//   REG_W / RADDR_W : register width and register-number width
//   REG_ZERO/REG_RA : architectural register numbers for $zero and $ra
//   reg_addr_t      : 5-bit register number
//   word_t          : 32-bit data word
package mips_pkg;

  localparam int REG_W   = 32;
  localparam int RADDR_W = 5;

  typedef logic [RADDR_W-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]   word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/decoder_5to32.sv
// decoder_5to32: purely combinational enable-gated binary-to-one-hot decoder.
//   en      : decode enable; when low the output is all zeros
//   addr    : register number to decode
//   onehot  : one-hot of addr when en=1, zero otherwise
module decoder_5to32
  import mips_pkg::*;
#(
  parameter int ADDR_W = RADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  // The enable is applied before the address is used, so an unknown address
  // with en=0 still produces a clean all-zero output.
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/mips_regfile_wb.sv
// mips_regfile_wb: MIPS register file, write-back side.
//   clock     : rising-edge clock
//   reset     : synchronous active-high; clears every register and wr_onehot
//   wr_en     : write-back valid (RegWrite)
//   wr_addr   : destination register number from the upstream select mux
//   wr_data   : write-back value
//   rd_addr1/2: read port register numbers (rs / rt)
//   rd_data1/2: combinational read data; $zero always reads 0
//   wr_onehot : registered one-hot of the last accepted write (trace/debug)
// BYPASS=1 forwards wr_data to a read of the register being written in the
// same cycle; BYPASS=0 returns the old contents until the next cycle.
module mips_regfile_wb
  import mips_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = RADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0]    rd_addr1,
  input  logic [ADDR_W-1:0]    rd_addr2,
  output logic [DATA_W-1:0]    rd_data1,
  output logic [DATA_W-1:0]    rd_data2,
  output logic [2**ADDR_W-1:0] wr_onehot
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [NREGS-1:0]  dec_onehot;
  logic [NREGS-1:0]  sel;
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  onehot_d;
  logic [NREGS-1:0]  onehot_q;

  decoder_5to32 #(.ADDR_W(ADDR_W)) u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (dec_onehot)
  );

  // $zero is not writable: drop its select bit before it reaches storage.
  assign sel      = dec_onehot & ~NREGS'(1);
  assign onehot_d = sel;

  // NOTE: every always_comb output gets a full default first (here: hold all
  // registers) so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < NREGS; i++) begin
      if (sel[i]) regs_d[i] = wr_data;
    end
    regs_d[0] = '0;
  end

  // NOTE: the storage array is reset on purpose -- the architecture requires a
  // one-cycle clear of all registers, so this is flops, not an inferred RAM.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q   <= '{default: '0};
      onehot_q <= '0;
    end else begin
      regs_q   <= regs_d;
      onehot_q <= onehot_d;
    end
  end

  assign wr_onehot = onehot_q;

  // Read ports: array lookup, optional same-cycle forward, then $zero override
  // last so address 0 reads 0 even when a write to r0 is being bypassed.
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    if (BYPASS && wr_en && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if (rd_addr1 == ZERO_ADDR) rd_data1 = '0;
  end

  always_comb begin
    rd_data2 = regs_q[rd_addr2];
    if (BYPASS && wr_en && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    if (rd_addr2 == ZERO_ADDR) rd_data2 = '0;
  end

endmodule

// File: tb/tb_mips_regfile_wb.sv
// tb_mips_regfile_wb: self-checking bench for mips_regfile_wb. Two instances
// share one set of inputs: one with BYPASS=1 and one with BYPASS=0. A plain
// array model holds the architectural register contents.
module tb_mips_regfile_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic [31:0] b_oh, n_oh;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [31:0] model_oh;

  always #5 clock = ~clock;

  mips_regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .wr_onehot(b_oh)
  );

  mips_regfile_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nobyp (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .wr_onehot(n_oh)
  );

  // Expected read value from the architectural rules.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  // Advance one clock; the model commits the inputs present at the edge.
  task automatic cycle();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_oh = 32'h0;
    end else if (wr_en && wr_addr != 5'd0) begin
      model[wr_addr] = wr_data;
      model_oh = 32'h1 << wr_addr;
    end else begin
      model_oh = 32'h0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5a5a5a5a;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    cycle();
    idle_inputs();
    rd_addr1 = 5'd5; rd_addr2 = 5'd31;
    #1;
    checks += 4;
    if (b_rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1_byp: got %h expected %h", b_rd1, 32'h0); end
    if (b_rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2_byp: got %h expected %h", b_rd2, 32'h0); end
    if (n_rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1_nobyp: got %h expected %h", n_rd1, 32'h0); end
    if (b_oh !== 32'h0 || n_oh !== 32'h0) begin errors++; $display("FAIL reset_onehot: got %h/%h expected 0", b_oh, n_oh); end
  endtask

  task automatic test_basic_write();
    write_reg(5'd8, 32'hdeadbeef);
    rd_addr1 = 5'd8; rd_addr2 = 5'd5;
    #1;
    checks += 3;
    if (b_rd1 !== 32'hdeadbeef) begin errors++; $display("FAIL basic_rd1_byp: got %h expected %h", b_rd1, 32'hdeadbeef); end
    if (n_rd1 !== 32'hdeadbeef) begin errors++; $display("FAIL basic_rd1_nobyp: got %h expected %h", n_rd1, 32'hdeadbeef); end
    if (b_oh !== 32'h00000100 || n_oh !== 32'h00000100) begin errors++; $display("FAIL basic_onehot: got %h/%h expected %h", b_oh, n_oh, 32'h100); end
    cycle();
    checks++;
    if (b_oh !== 32'h0 || n_oh !== 32'h0) begin errors++; $display("FAIL basic_onehot_clear: got %h/%h expected 0", b_oh, n_oh); end
  endtask

  task automatic test_zero();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    checks += 2;
    if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin errors++; $display("FAIL zero_bypass: got %h/%h expected 0", b_rd1, b_rd2); end
    if (n_rd1 !== 32'h0 || n_rd2 !== 32'h0) begin errors++; $display("FAIL zero_nobyp_same: got %h/%h expected 0", n_rd1, n_rd2); end
    cycle();
    wr_en = 1'b0;
    #1;
    checks += 2;
    if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0 || n_rd1 !== 32'h0) begin errors++; $display("FAIL zero_after: got %h/%h/%h expected 0", b_rd1, b_rd2, n_rd1); end
    if (b_oh !== 32'h0 || n_oh !== 32'h0) begin errors++; $display("FAIL zero_onehot: got %h/%h expected 0", b_oh, n_oh); end
  endtask

  task automatic test_bypass();
    write_reg(5'd9, 32'h00000001);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hcafef00d;
    rd_addr1 = 5'd9; rd_addr2 = 5'd9;
    #1;
    checks += 2;
    if (b_rd1 !== 32'hcafef00d || b_rd2 !== 32'hcafef00d) begin errors++; $display("FAIL bypass_on: got %h/%h expected %h", b_rd1, b_rd2, 32'hcafef00d); end
    if (n_rd1 !== 32'h00000001 || n_rd2 !== 32'h00000001) begin errors++; $display("FAIL bypass_off_same: got %h/%h expected %h", n_rd1, n_rd2, 32'h1); end
    cycle();
    wr_en = 1'b0;
    #1;
    checks++;
    if (n_rd1 !== 32'hcafef00d || n_rd2 !== 32'hcafef00d) begin errors++; $display("FAIL bypass_off_next: got %h/%h expected %h", n_rd1, n_rd2, 32'hcafef00d); end
  endtask

  task automatic test_reset_vs_write();
    write_reg(5'd31, 32'haaaa5555);
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h11111111;
    rd_addr1 = 5'd31; rd_addr2 = 5'd9;
    #1;
    // Reads during reset still show pre-clear contents.
    checks++;
    if (n_rd1 !== 32'haaaa5555 || n_rd2 !== 32'hcafef00d) begin errors++; $display("FAIL reset_preclear: got %h/%h expected %h/%h", n_rd1, n_rd2, 32'haaaa5555, 32'hcafef00d); end
    cycle();
    idle_inputs();
    #1;
    checks += 2;
    if (b_rd1 !== 32'h0 || n_rd1 !== 32'h0 || n_rd2 !== 32'h0) begin errors++; $display("FAIL reset_priority: got %h/%h/%h expected 0", b_rd1, n_rd1, n_rd2); end
    if (b_oh !== 32'h0 || n_oh !== 32'h0) begin errors++; $display("FAIL reset_priority_onehot: got %h/%h expected 0", b_oh, n_oh); end
  endtask

  task automatic test_write_gating();
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    for (int c = 0; c < 50; c++) begin
      wr_en = 1'b0;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      rd_addr1 = 5'($urandom_range(0, 31));
      rd_addr2 = 5'($urandom_range(0, 31));
      cycle();
      checks++;
      if (b_oh !== 32'h0 || n_oh !== 32'h0) begin errors++; $display("FAIL gating_onehot[%0d]: got %h/%h expected 0", c, b_oh, n_oh); end
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
      #1;
      checks++;
      if (b_rd1 !== 32'(i) || n_rd2 !== 32'(31 - i)) begin
        errors++; $display("FAIL gating_hold r%0d: got %h/%h expected %h/%h", i, b_rd1, n_rd2, 32'(i), 32'(31 - i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    for (int k = 0; k < 3; k++) vals[k] = $urandom;
    rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    for (int k = 0; k < 3; k++) begin
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = vals[k];
      cycle();
      #1;
      checks++;
      if (b_oh !== 32'h20) begin errors++; $display("FAIL b2b_onehot[%0d]: got %h expected %h", k, b_oh, 32'h20); end
    end
    wr_en = 1'b0;
    #1;
    checks++;
    if (n_rd1 !== vals[2] || b_rd2 !== vals[2]) begin errors++; $display("FAIL b2b_last_wins: got %h/%h expected %h", n_rd1, b_rd2, vals[2]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (b_rd1 !== exp_read(rd_addr1, 1'b1) || b_rd2 !== exp_read(rd_addr2, 1'b1) ||
          n_rd1 !== exp_read(rd_addr1, 1'b0) || n_rd2 !== exp_read(rd_addr2, 1'b0)) begin
        errors++;
        $display("FAIL random_read[%0d]: got %h %h %h %h expected %h %h %h %h", c,
                 b_rd1, b_rd2, n_rd1, n_rd2, exp_read(rd_addr1, 1'b1), exp_read(rd_addr2, 1'b1),
                 exp_read(rd_addr1, 1'b0), exp_read(rd_addr2, 1'b0));
      end
      cycle();
      checks++;
      if (b_oh !== model_oh || n_oh !== model_oh) begin errors++; $display("FAIL random_onehot[%0d]: got %h/%h expected %h", c, b_oh, n_oh, model_oh); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_oh = 32'h0;
    idle_inputs();
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    test_reset();
    test_basic_write();
    test_zero();
    test_bypass();
    test_reset_vs_write();
    test_write_gating();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
